// File: rtl/mem_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between CPU and debug masters, fixed DBG
//            priority with a starvation bound; optional macro ARB_DBG_LOCK_EN.
// Revision : 1.0 - initial release
// =====================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sign,
    output logic              cpu_gnt,
    output logic              cpu_rsp,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [1:0]        dbg_size,
    input  logic              dbg_sign,
    output logic              dbg_gnt,
    output logic              dbg_rsp,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    input  logic              dbg_lock,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic [DATA_W-1:0] mem_out,
    input  logic              mem_error
);

    localparam int              C_SW  = $clog2(MAX_BURST + 1);
    localparam logic [C_SW-1:0] C_MAX = C_SW'(MAX_BURST);
    localparam logic [C_SW-1:0] C_ONE = C_SW'(1);

    logic w_lock;
`ifdef ARB_DBG_LOCK_EN
    assign w_lock = dbg_lock;
`else
    logic w_unused_lock;
    assign w_lock        = 1'b0;
    assign w_unused_lock = dbg_lock;
`endif

    logic [C_SW-1:0] r_starve;
    logic            w_cpu_win;
    logic            w_dbg_win;
    logic            w_any;
    logic            w_sel_we;

    // Arbitration winners before reset gating; the starve counter uses these.
    assign w_cpu_win = cpu_req & ~w_lock & (~dbg_req | (r_starve == C_MAX));
    assign w_dbg_win = dbg_req & ~w_cpu_win;

    assign cpu_gnt  = w_cpu_win & ~rst;
    assign dbg_gnt  = w_dbg_win & ~rst;
    assign w_any    = cpu_gnt | dbg_gnt;
    assign w_sel_we = w_dbg_win ? dbg_we : cpu_we;

    assign mem_we   = w_any & w_sel_we;
    assign mem_rd   = w_any & ~w_sel_we;
    assign mem_addr = w_dbg_win ? dbg_addr  : cpu_addr;
    assign mem_data = w_dbg_win ? dbg_wdata : cpu_wdata;
    assign mem_size = w_dbg_win ? dbg_size  : cpu_size;
    assign mem_sign = w_dbg_win ? dbg_sign  : cpu_sign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!w_lock) begin
            if (!cpu_req || w_cpu_win) begin
                r_starve <= '0;
            end else if (w_dbg_win && (r_starve != C_MAX)) begin
                r_starve <= r_starve + C_ONE;
            end
        end
    end

    // Response tracking: one {valid, owner(1=DBG), is_read} entry per stage.
    logic [RD_LATENCY-1:0] r_vld;
    logic [RD_LATENCY-1:0] r_own;
    logic [RD_LATENCY-1:0] r_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_own <= '0;
            r_rd  <= '0;
        end else begin
            r_vld[0] <= w_cpu_win | w_dbg_win;
            r_own[0] <= w_dbg_win;
            r_rd[0]  <= ~w_sel_we;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_own[i] <= r_own[i-1];
                r_rd[i]  <= r_rd[i-1];
            end
        end
    end

    logic w_rsp_rd;
    assign w_rsp_rd  = r_rd[RD_LATENCY-1];
    assign cpu_rsp   = r_vld[RD_LATENCY-1] & ~r_own[RD_LATENCY-1];
    assign dbg_rsp   = r_vld[RD_LATENCY-1] &  r_own[RD_LATENCY-1];
    assign cpu_err   = cpu_rsp & mem_error;
    assign dbg_err   = dbg_rsp & mem_error;
    assign cpu_rdata = (cpu_rsp & w_rsp_rd) ? mem_out : '0;
    assign dbg_rdata = (dbg_rsp & w_rsp_rd) ? mem_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: directed scenarios plus
//            randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 1;
    localparam int MB  = 4;
    localparam int N   = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cpu_req, cpu_we, cpu_sign, cpu_gnt, cpu_rsp, cpu_err;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic [1:0]    cpu_size;
    logic          dbg_req, dbg_we, dbg_sign, dbg_gnt, dbg_rsp, dbg_err, dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic [1:0]    dbg_size;
    logic          mem_rd, mem_we, mem_sign, mem_error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, mem_out;
    logic [1:0]    mem_size;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_gnt(cpu_gnt), .cpu_rsp(cpu_rsp),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_size(dbg_size), .dbg_sign(dbg_sign), .dbg_gnt(dbg_gnt), .dbg_rsp(dbg_rsp),
        .dbg_rdata(dbg_rdata), .dbg_err(dbg_err), .dbg_lock(dbg_lock),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_size(mem_size), .mem_sign(mem_sign), .mem_out(mem_out), .mem_error(mem_error)
    );

    // Memory: 64 words, fixed-latency read data, error injected per command.
    logic [31:0] mem_arr [0:63];
    logic [31:0] pipe_d  [0:LAT-1];
    logic        pipe_e  [0:LAT-1];
    logic        err_inject;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++)
                mem_arr[i] <= (i == 4) ? 32'hDEADBEEF : (32'hA5A50000 + i);
        end else if (mem_we) begin
            mem_arr[mem_addr[7:2]] <= mem_data;
        end
        pipe_d[0] <= mem_rd ? mem_arr[mem_addr[7:2]] : 32'h0;
        pipe_e[0] <= (mem_rd | mem_we) & err_inject;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_e[i] <= pipe_e[i-1];
        end
    end
    assign mem_out   = pipe_d[LAT-1];
    assign mem_error = pipe_e[LAT-1];

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_size = 2'd2; cpu_sign = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_size = 2'd2; dbg_sign = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cpu_req = 1; dbg_req = 1; dbg_we = 1;
        #2;
        checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst_cpu_gnt got %0b want 0", cpu_gnt); end
        checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL rst_dbg_gnt got %0b want 0", dbg_gnt); end
        checks++; if ({mem_rd, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_mem_cmd got %b want 00", {mem_rd, mem_we}); end
        checks++; if ({cpu_rsp, dbg_rsp, cpu_err, dbg_err} !== 4'b0) begin errors++; $display("FAIL rst_rsp got %b want 0000", {cpu_rsp, dbg_rsp, cpu_err, dbg_err}); end
        checks++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h want 0", cpu_rdata, dbg_rdata); end
        idle();
        rst = 0;
        tick();
        #4;
        checks++; if ({cpu_gnt, dbg_gnt, mem_rd, mem_we, cpu_rsp, dbg_rsp} !== 6'b0) begin errors++; $display("FAIL idle_outputs got %b want 000000", {cpu_gnt, dbg_gnt, mem_rd, mem_we, cpu_rsp, dbg_rsp}); end
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #4;
        checks++; if ({cpu_gnt, dbg_gnt} !== 2'b10) begin errors++; $display("FAIL cpu_read_gnt got %b want 10", {cpu_gnt, dbg_gnt}); end
        checks++; if (mem_rd !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin errors++; $display("FAIL cpu_read_cmd got rd=%0b we=%0b addr=%h want 1 0 10", mem_rd, mem_we, mem_addr); end
        tick();
        idle();
        #4;
        checks++; if (cpu_rsp !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_read_rsp got rsp=%0b data=%h want 1 deadbeef", cpu_rsp, cpu_rdata); end
        checks++; if (dbg_rsp !== 1'b0 || cpu_err !== 1'b0) begin errors++; $display("FAIL cpu_read_side got dbg_rsp=%0b err=%0b want 0 0", dbg_rsp, cpu_err); end
        tick();
    endtask

    task automatic test_contention();
        string order;
        logic  want_c;
        order = "DDDDCDDDDC";
        cpu_req = 1; cpu_addr = 32'h8; dbg_req = 1; dbg_addr = 32'hC;
        for (int i = 0; i < 10; i++) begin
            want_c = (order[i] == "C");
            #4;
            checks++; if ({cpu_gnt, dbg_gnt} !== {want_c, ~want_c}) begin errors++; $display("FAIL contention_c%0d got cpu/dbg %b want %b", i, {cpu_gnt, dbg_gnt}, {want_c, ~want_c}); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h5;
        #4;
        checks++; if (dbg_gnt !== 1'b1 || mem_we !== 1'b1 || mem_data !== 32'h5) begin errors++; $display("FAIL b2b_wr got gnt=%0b we=%0b data=%h want 1 1 5", dbg_gnt, mem_we, mem_data); end
        tick();
        idle();
        cpu_req = 1; cpu_addr = 32'h20;
        #4;
        checks++; if (cpu_gnt !== 1'b1 || mem_rd !== 1'b1) begin errors++; $display("FAIL b2b_rd_gnt got gnt=%0b rd=%0b want 1 1", cpu_gnt, mem_rd); end
        checks++; if (dbg_rsp !== 1'b1 || dbg_rdata !== 32'h0 || cpu_rsp !== 1'b0) begin errors++; $display("FAIL b2b_wr_rsp got dbg_rsp=%0b rdata=%h cpu_rsp=%0b want 1 0 0", dbg_rsp, dbg_rdata, cpu_rsp); end
        tick();
        idle();
        #4;
        checks++; if (cpu_rsp !== 1'b1 || cpu_rdata !== 32'h5 || dbg_rsp !== 1'b0) begin errors++; $display("FAIL b2b_rd_rsp got rsp=%0b data=%h dbg_rsp=%0b want 1 5 0", cpu_rsp, cpu_rdata, dbg_rsp); end
        tick();
    endtask

    task automatic test_error();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h24; dbg_wdata = 32'h7; err_inject = 1;
        #4;
        checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL err_gnt got %0b want 1", dbg_gnt); end
        tick();
        idle();
        err_inject = 0;
        #4;
        checks++; if (dbg_rsp !== 1'b1 || dbg_err !== 1'b1 || dbg_rdata !== 32'h0) begin errors++; $display("FAIL err_rsp got rsp=%0b err=%0b data=%h want 1 1 0", dbg_rsp, dbg_err, dbg_rdata); end
        checks++; if (cpu_err !== 1'b0 || cpu_rsp !== 1'b0) begin errors++; $display("FAIL err_cpu_side got err=%0b rsp=%0b want 0 0", cpu_err, cpu_rsp); end
        tick();
    endtask

    task automatic test_reset_inflight();
        cpu_req = 1; cpu_addr = 32'h10;
        #4;
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL inflight_gnt got %0b want 1", cpu_gnt); end
        tick();
        rst = 1;
        #1;
        checks++; if ({cpu_gnt, cpu_rsp, mem_rd} !== 3'b000 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL inflight_rst got gnt/rsp/rd=%b data=%h want 000 0", {cpu_gnt, cpu_rsp, mem_rd}, cpu_rdata); end
        idle();
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++; if ({cpu_rsp, dbg_rsp} !== 2'b00) begin errors++; $display("FAIL inflight_after%0d got rsp %b want 00", i, {cpu_rsp, dbg_rsp}); end
            tick();
        end
    endtask

    task automatic contested_expect(input string order, input string tag);
        logic want_c;
        cpu_req = 1; dbg_req = 1;
        for (int i = 0; i < order.len(); i++) begin
            want_c = (order[i] == "C");
            #4;
            checks++; if ({cpu_gnt, dbg_gnt} !== {want_c, ~want_c}) begin errors++; $display("FAIL %s_c%0d got cpu/dbg %b want %b", tag, i, {cpu_gnt, dbg_gnt}, {want_c, ~want_c}); end
            tick();
        end
    endtask

`ifdef ARB_DBG_LOCK_EN
    task automatic test_lock();
        contested_expect("DD", "prelock");
        dbg_lock = 1;
        contested_expect("DDDDDDDD", "lock");
        dbg_lock = 0;
        contested_expect("DDC", "unlock");
        idle();
        tick();
    endtask
`else
    task automatic test_lock();
        dbg_lock = 1;
        contested_expect("DDDDC", "lock_ignored");
        dbg_lock = 0;
        idle();
        tick();
    endtask
`endif

    typedef struct {
        int          due;
        bit          own_dbg;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    task automatic test_random();
        rsp_t        q[$];
        rsp_t        e;
        logic [31:0] mdl [0:63];
        int          run;
        bit          cpend, dpend, exp_c, exp_d, g_we;
        logic [31:0] g_addr, g_wdata;
        logic [1:0]  g_size;
        logic        g_sign;
        run = 0; cpend = 0; dpend = 0;
        for (int i = 0; i < 64; i++) mdl[i] = mem_arr[i];
        for (int c = 0; c < N + LAT + 2; c++) begin
            if (!cpend && c < N && $urandom_range(0, 9) < 6) begin
                cpend = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                cpu_wdata = $urandom; cpu_size = 2'($urandom_range(0, 2)); cpu_sign = 1'($urandom_range(0, 1));
            end
            if (!dpend && c < N && $urandom_range(0, 9) < 6) begin
                dpend = 1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                dbg_wdata = $urandom; dbg_size = 2'($urandom_range(0, 2)); dbg_sign = 1'($urandom_range(0, 1));
            end
            cpu_req = cpend; dbg_req = dpend;
            err_inject = ($urandom_range(0, 7) == 0);
            #4;
            // DBG wins unless the CPU has waited through MB contested DBG grants.
            exp_c = cpend && (!dpend || run == MB);
            exp_d = dpend && !exp_c;
            run   = (exp_d && cpend) ? ((run < MB) ? run + 1 : MB) : 0;
            checks++; if ({cpu_gnt, dbg_gnt} !== {exp_c, exp_d}) begin errors++; $display("FAIL rnd_gnt c%0d got %b want %b", c, {cpu_gnt, dbg_gnt}, {exp_c, exp_d}); end
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                checks++;
                if ({cpu_rsp, dbg_rsp} !== {~e.own_dbg, e.own_dbg} ||
                    (e.own_dbg ? dbg_rdata : cpu_rdata) !== e.data ||
                    (e.own_dbg ? dbg_err : cpu_err) !== e.err ||
                    (e.own_dbg ? {cpu_rdata, cpu_err} : {dbg_rdata, dbg_err}) !== 33'h0) begin
                    errors++;
                    $display("FAIL rnd_rsp c%0d got rsp=%b cdata=%h ddata=%h err=%b want rsp=%b data=%h err=%0b",
                             c, {cpu_rsp, dbg_rsp}, cpu_rdata, dbg_rdata, {cpu_err, dbg_err}, {~e.own_dbg, e.own_dbg}, e.data, e.err);
                end
            end else begin
                checks++; if ({cpu_rsp, dbg_rsp} !== 2'b00) begin errors++; $display("FAIL rnd_norsp c%0d got %b want 00", c, {cpu_rsp, dbg_rsp}); end
            end
            if (exp_c || exp_d) begin
                g_we    = exp_d ? dbg_we : cpu_we;
                g_addr  = exp_d ? dbg_addr : cpu_addr;
                g_wdata = exp_d ? dbg_wdata : cpu_wdata;
                g_size  = exp_d ? dbg_size : cpu_size;
                g_sign  = exp_d ? dbg_sign : cpu_sign;
                checks++;
                if ({mem_rd, mem_we} !== {~g_we, g_we} || mem_addr !== g_addr || mem_size !== g_size ||
                    mem_sign !== g_sign || (g_we && mem_data !== g_wdata)) begin
                    errors++;
                    $display("FAIL rnd_cmd c%0d got rd=%0b we=%0b a=%h d=%h s=%0d sg=%0b want we=%0b a=%h d=%h s=%0d sg=%0b",
                             c, mem_rd, mem_we, mem_addr, mem_data, mem_size, mem_sign, g_we, g_addr, g_wdata, g_size, g_sign);
                end
                e.due = c + LAT; e.own_dbg = exp_d; e.err = err_inject;
                e.data = g_we ? 32'h0 : mdl[g_addr[7:2]];
                if (g_we) mdl[g_addr[7:2]] = g_wdata;
                q.push_back(e);
                if (exp_c) cpend = 0;
                if (exp_d) dpend = 0;
            end
            tick();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending want 0", q.size()); end
        idle();
        err_inject = 0;
        tick();
    endtask

    initial begin
        rst = 1; dbg_lock = 0; err_inject = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_cpu_read();
        test_contention();
        test_back_to_back();
        test_error();
        test_reset_inflight();
        test_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
